// File: rtl/register_bank_pkg.sv
// Shared uCISC register-bank encodings: arithmetic mode, read bypass mode and
// increment range classification. Overflow flag bit i always belongs to entry i.
package register_bank_pkg;

  localparam int SAT_WRAP   = 0;
  localparam int SAT_CLAMP  = 1;
  localparam int BYPASS_OFF = 0;
  localparam int BYPASS_ON  = 1;

  typedef enum logic [1:0] {
    ARITH_IN_RANGE = 2'd0,
    ARITH_OVER     = 2'd1,
    ARITH_UNDER    = 2'd2
  } arith_status_e;

  // The sum is formed two bits wider than the entry: the top bit is the sign,
  // the next one is the carry past the unsigned range.
  function automatic arith_status_e classify(input logic sign_bit, input logic carry_bit);
    if (sign_bit) return ARITH_UNDER;
    if (carry_bit) return ARITH_OVER;
    return ARITH_IN_RANGE;
  endfunction

endpackage

// File: rtl/register_slice.sv
// One bank entry plus its sticky overflow flag; write beats increment.
// Latency: state updates on the rising edge, value/flag visible next cycle.
// Backpressure: none, always accepts whatever its enables present.
module register_slice
  import register_bank_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             inc_en,
  input  logic [WIDTH-1:0] inc_data,
  input  logic             inc_ovf,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  always_ff @(posedge clock) begin
    if (reset) begin
      value <= INIT;
      ovf   <= 1'b0;
    end else if (wr_en) begin
      value <= wr_data;
      ovf   <= 1'b0;
    end else if (inc_en) begin
      value <= inc_data;
      if (inc_ovf) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/register_bank.sv
// DEPTH-entry register bank with one write port and one signed-increment port.
// Latency: writes/increments land at the next edge; reads and inc_result are combinational.
// Backpressure: none, the bank is always ready.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter int               ADDR_WIDTH = 2,
  parameter logic [WIDTH-1:0] INIT       = '0,
  parameter int               SATURATE   = SAT_WRAP,
  parameter int               BYPASS     = BYPASS_ON
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       write_enable,
  input  logic [ADDR_WIDTH-1:0]      write_addr,
  input  logic [WIDTH-1:0]           write_data,
  input  logic                       inc_enable,
  input  logic [ADDR_WIDTH-1:0]      inc_addr,
  input  logic [WIDTH-1:0]           increment,
  input  logic [ADDR_WIDTH-1:0]      read_addr_a,
  input  logic [ADDR_WIDTH-1:0]      read_addr_b,
  output logic [WIDTH-1:0]           read_value_a,
  output logic [WIDTH-1:0]           read_value_b,
  output logic [WIDTH-1:0]           inc_result,
  output logic [(2**ADDR_WIDTH)-1:0] overflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] entry [DEPTH];
  logic [WIDTH-1:0] inc_base;
  logic [WIDTH+1:0] sum;
  arith_status_e    status;
  logic             inc_ovf;

  // inc_result is built from stored state only, so a same-cycle write never feeds it.
  assign inc_base = entry[inc_addr];
  assign sum      = {2'b00, inc_base} + {{2{increment[WIDTH-1]}}, increment};
  assign status   = classify(sum[WIDTH+1], sum[WIDTH]);
  assign inc_ovf  = (status != ARITH_IN_RANGE);

  always_comb begin
    inc_result = sum[WIDTH-1:0];
    if (SATURATE == SAT_CLAMP) begin
      if (status == ARITH_UNDER) inc_result = '0;
      else if (status == ARITH_OVER) inc_result = '1;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    logic wr_sel;
    logic inc_sel;

    // A write to the same entry suppresses the increment entirely.
    assign wr_sel  = write_enable && (write_addr == ADDR_WIDTH'(i));
    assign inc_sel = inc_enable && (inc_addr == ADDR_WIDTH'(i)) && !wr_sel;

    register_slice #(
      .WIDTH (WIDTH),
      .INIT  (INIT)
    ) u_slice (
      .clock    (clock),
      .reset    (reset),
      .wr_en    (wr_sel),
      .wr_data  (write_data),
      .inc_en   (inc_sel),
      .inc_data (inc_result),
      .inc_ovf  (inc_ovf),
      .value    (entry[i]),
      .ovf      (overflow[i])
    );
  end

  always_comb begin
    read_value_a = entry[read_addr_a];
    read_value_b = entry[read_addr_b];
    if (BYPASS == BYPASS_ON && write_enable) begin
      if (read_addr_a == write_addr) read_value_a = write_data;
      if (read_addr_b == write_addr) read_value_b = write_data;
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed bench: a wrap/bypass bank (INIT=5) and a saturate/no-bypass bank (INIT=0)
// sharing one stimulus stream.
module tb_register_bank;

  logic        clock;
  logic        reset;
  logic        write_enable;
  logic [1:0]  write_addr;
  logic [15:0] write_data;
  logic        inc_enable;
  logic [1:0]  inc_addr;
  logic [15:0] increment;
  logic [1:0]  read_addr_a;
  logic [1:0]  read_addr_b;

  logic [15:0] rva_w, rvb_w, ir_w;
  logic [3:0]  ov_w;
  logic [15:0] rva_s, rvb_s, ir_s;
  logic [3:0]  ov_s;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        ie;
    logic [1:0]  ia;
    logic [15:0] inc;
    logic [1:0]  ra;
    logic [1:0]  rb;
    logic [15:0] ea;
    logic [15:0] eb;
    logic [15:0] eir;
    logic [3:0]  eov;
  } vec_t;

  vec_t vecs [16];

  register_bank #(
    .WIDTH(16), .ADDR_WIDTH(2), .INIT(16'h0005), .SATURATE(0), .BYPASS(1)
  ) dut_w (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .inc_enable(inc_enable), .inc_addr(inc_addr), .increment(increment),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_value_a(rva_w), .read_value_b(rvb_w),
    .inc_result(ir_w), .overflow(ov_w)
  );

  register_bank #(
    .WIDTH(16), .ADDR_WIDTH(2), .INIT(16'h0000), .SATURATE(1), .BYPASS(0)
  ) dut_s (
    .clock(clock), .reset(reset),
    .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
    .inc_enable(inc_enable), .inc_addr(inc_addr), .increment(increment),
    .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
    .read_value_a(rva_s), .read_value_b(rvb_s),
    .inc_result(ir_s), .overflow(ov_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd2, 16'h0000, 2'd2, 2'd1, 16'hBEEF, 16'h0005, 16'h0005, 4'b0000};
    vecs[1]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd2, 16'h0000, 2'd2, 2'd2, 16'hBEEF, 16'hBEEF, 16'hBEEF, 4'b0000};
    vecs[2]  = '{1'b1, 2'd1, 16'hFFFE, 1'b0, 2'd1, 16'h0000, 2'd1, 2'd0, 16'hFFFE, 16'h0005, 16'h0005, 4'b0000};
    vecs[3]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'h0003, 2'd1, 2'd2, 16'hFFFE, 16'hBEEF, 16'h0001, 4'b0000};
    vecs[4]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'hFFFE, 2'd1, 2'd1, 16'h0001, 16'h0001, 16'hFFFF, 4'b0010};
    vecs[5]  = '{1'b1, 2'd1, 16'h0000, 1'b0, 2'd1, 16'h0000, 2'd1, 2'd3, 16'h0000, 16'h0005, 16'hFFFF, 4'b0010};
    vecs[6]  = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0000, 2'd1, 2'd0, 16'h0000, 16'h0005, 16'h0000, 4'b0000};
    vecs[7]  = '{1'b1, 2'd2, 16'hFFFF, 1'b0, 2'd2, 16'h0000, 2'd2, 2'd3, 16'hFFFF, 16'h0005, 16'hBEEF, 4'b0000};
    vecs[8]  = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd2, 16'h0011, 2'd2, 2'd2, 16'hFFFF, 16'hFFFF, 16'h0010, 4'b0000};
    vecs[9]  = '{1'b1, 2'd2, 16'h1234, 1'b1, 2'd2, 16'h0001, 2'd2, 2'd0, 16'h1234, 16'h0005, 16'h0011, 4'b0100};
    vecs[10] = '{1'b1, 2'd0, 16'h00A0, 1'b1, 2'd3, 16'h0001, 2'd2, 2'd3, 16'h1234, 16'h0005, 16'h0006, 4'b0000};
    vecs[11] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd3, 16'hFFFF, 2'd0, 2'd3, 16'h00A0, 16'h0006, 16'h0005, 4'b0000};
    vecs[12] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd0, 16'h0000, 2'd0, 2'd0, 16'h00A0, 16'h00A0, 16'h00A0, 4'b0000};
    vecs[13] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd1, 16'h00A0, 16'h0000, 16'h00A0, 4'b0000};
    vecs[14] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 16'hFFFB, 2'd1, 2'd2, 16'h0000, 16'h1234, 16'hFFFB, 4'b0000};
    vecs[15] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd1, 16'h0000, 2'd1, 2'd1, 16'hFFFB, 16'hFFFB, 16'hFFFB, 4'b0010};

    // Reset with a write presented in the same cycles; the write must be dropped.
    reset = 1'b1;
    write_enable = 1'b1; write_addr = 2'd0; write_data = 16'hAAAA;
    inc_enable = 1'b0; inc_addr = 2'd0; increment = 16'h0000;
    read_addr_a = 2'd0; read_addr_b = 2'd1;
    edge_step();
    edge_step();
    reset = 1'b0; write_enable = 1'b0; inc_addr = 2'd2;
    #2;
    check("rst_w_a0", rva_w, 16'h0005);
    check("rst_w_b1", rvb_w, 16'h0005);
    check("rst_w_ir", ir_w, 16'h0005);
    check("rst_w_ov", ov_w, 4'b0000);
    check("rst_s_a0", rva_s, 16'h0000);
    check("rst_s_ov", ov_s, 4'b0000);
    read_addr_a = 2'd2; read_addr_b = 2'd3;
    #2;
    check("rst_w_a2", rva_w, 16'h0005);
    check("rst_w_b3", rvb_w, 16'h0005);

    for (int i = 0; i < 16; i++) begin
      write_enable = vecs[i].we; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      inc_enable = vecs[i].ie; inc_addr = vecs[i].ia; increment = vecs[i].inc;
      read_addr_a = vecs[i].ra; read_addr_b = vecs[i].rb;
      #2;
      check($sformatf("vec%0d read_a", i), rva_w, vecs[i].ea);
      check($sformatf("vec%0d read_b", i), rvb_w, vecs[i].eb);
      check($sformatf("vec%0d inc_result", i), ir_w, vecs[i].eir);
      check($sformatf("vec%0d overflow", i), ov_w, vecs[i].eov);
      edge_step();
    end

    // Saturating bank: no bypass on write, clamp high and low.
    write_enable = 1'b1; write_addr = 2'd0; write_data = 16'hFFFE;
    inc_enable = 1'b0; read_addr_a = 2'd0; read_addr_b = 2'd0;
    #2;
    check("sat_nobypass", rva_s, 16'h00A0);
    check("wrap_bypass", rva_w, 16'hFFFE);
    edge_step();
    write_enable = 1'b1; write_addr = 2'd3; write_data = 16'h0001;
    inc_enable = 1'b1; inc_addr = 2'd0; increment = 16'h0003;
    #2;
    check("sat_hi_ir", ir_s, 16'hFFFF);
    check("sat_hi_wrap_ir", ir_w, 16'h0001);
    check("sat_hi_read", rva_s, 16'hFFFE);
    edge_step();
    write_enable = 1'b0; inc_enable = 1'b1; inc_addr = 2'd3; increment = 16'hFFFB;
    read_addr_a = 2'd0; read_addr_b = 2'd3;
    #2;
    check("sat_lo_ir", ir_s, 16'h0000);
    check("sat_e0", rva_s, 16'hFFFF);
    check("sat_e3", rvb_s, 16'h0001);
    check("sat_ov_mid", ov_s, 4'b0011);
    edge_step();
    inc_enable = 1'b0; read_addr_a = 2'd3; read_addr_b = 2'd0;
    #2;
    check("sat_lo_read", rva_s, 16'h0000);
    check("sat_hi_read2", rvb_s, 16'hFFFF);
    check("sat_ov_end", ov_s, 4'b1011);

    // Streaming increments on entry 3 of the saturating bank (INIT=0).
    write_enable = 1'b1; write_addr = 2'd3; write_data = 16'h0000;
    read_addr_a = 2'd3;
    edge_step();
    write_enable = 1'b0; inc_enable = 1'b1; inc_addr = 2'd3; increment = 16'h0001;
    for (int k = 1; k <= 8; k++) begin
      #2;
      check($sformatf("stream%0d ir", k), ir_s, 32'(k));
      check($sformatf("stream%0d read", k), rva_s, 32'(k - 1));
      edge_step();
    end
    inc_enable = 1'b0;
    #2;
    check("stream_final", rva_s, 16'h0008);

    write_enable = 1'b1; write_addr = 2'd3; write_data = 16'h0000;
    edge_step();
    write_enable = 1'b0;
    begin
      int cnt;
      cnt = 0;
      for (int k = 1; k <= 8; k++) begin
        inc_enable = 1'b1;
        reset = (k == 5);
        #2;
        check($sformatf("rstream%0d ir", k), ir_s, 32'(cnt + 1));
        check($sformatf("rstream%0d read", k), rva_s, 32'(cnt));
        edge_step();
        cnt = (k == 5) ? 0 : cnt + 1;
        reset = 1'b0;
      end
      inc_enable = 1'b0;
      #2;
      check("rstream_final", rva_s, 32'(cnt));
      check("rstream_w_ov", ov_w, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
